time_keeper: RTL

Time-of-day and alarm register block that sits directly downstream of the alarm-clock mode state machine. It consumes that FSM's mode enables, adjust flag and the debounced single-cycle up/down button pulses. It keeps the running HH:MM:SS time and the HH:MM alarm setting, and returns `Z` (alarm match) and `secs` to the FSM. It also drives the display multiplexer.

---
 rtl/clock_pkg.sv | 43 ++++
 rtl/tick_gen.sv | 25 ++
 rtl/time_keeper.sv | 96 +++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared constants, field select type and wrap helper for the alarm clock.
package clock_pkg;

  localparam int MAX_HOURS = 23;
  localparam int MAX_MINS  = 59;
  localparam int MAX_SECS  = 59;

  localparam int EN_TH  = 4;
  localparam int EN_TM  = 3;
  localparam int EN_AH  = 2;
  localparam int EN_AM  = 1;
  localparam int EN_RUN = 0;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  // Which field an up/down press is steered to.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TM,
    SEL_AH,
    SEL_AM
  } field_sel_t;

  // Highest set bit of EN[4:1] wins; no bit set means nothing is adjusted.
  function automatic field_sel_t select_field(input logic [3:0] en_hi);
    if (en_hi[3])      return SEL_TH;
    else if (en_hi[2]) return SEL_TM;
    else if (en_hi[1]) return SEL_AH;
    else if (en_hi[0]) return SEL_AM;
    else               return SEL_NONE;
  endfunction

  // One step up or down with wrap at 0 and max_v.
  function automatic logic [MIN_W-1:0] step_wrap(input logic [MIN_W-1:0] v,
                                                 input logic [MIN_W-1:0] max_v,
                                                 input logic inc);
    if (inc) return (v == max_v) ? '0 : v + 1'b1;
    else     return (v == '0) ? max_v : v - 1'b1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// 1 Hz prescaler: counts 0..CLK_HZ-1 while run, held at 0 otherwise.
module tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count;

  // Prescaler register: wraps after the terminal count, cleared when not running.
  always_ff @(posedge clk) begin
    if (!rst)                      count <= '0;
    else if (!run || count == LAST) count <= '0;
    else                           count <= count + 1'b1;
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/time_keeper.sv
// Time-of-day and alarm registers with adjust muxing and alarm match.
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        EN,
  input  logic              adjust,
  input  logic              up,
  input  logic              down,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  mins,
  output logic [MIN_W-1:0]  secs,
  output logic [HOUR_W-1:0] alarm_hours,
  output logic [MIN_W-1:0]  alarm_mins,
  output logic              Z,
  output logic              tick
);

  localparam logic [MIN_W-1:0] MAX_H6 = MIN_W'(MAX_HOURS);
  localparam logic [MIN_W-1:0] MAX_M6 = MIN_W'(MAX_MINS);
  localparam logic [MIN_W-1:0] MAX_S6 = MIN_W'(MAX_SECS);

  logic [HOUR_W-1:0] hours_next, alarm_hours_next;
  logic [MIN_W-1:0]  mins_next, secs_next, alarm_mins_next;
  field_sel_t        sel;
  logic              step, inc;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (EN[EN_RUN]),
    .tick (tick)
  );

  // Simultaneous up+down cancels; presses outside adjust belong to the FSM.
  assign sel  = select_field(EN[EN_TH:EN_AM]);
  assign step = adjust && (up ^ down);
  assign inc  = up;

  // Next-state for all fields: tick carry chain first, then the adjust step.
  always_comb begin
    hours_next       = hours;
    mins_next        = mins;
    secs_next        = secs;
    alarm_hours_next = alarm_hours;
    alarm_mins_next  = alarm_mins;

    if (tick) begin
      secs_next = step_wrap(secs, MAX_S6, 1'b1);
      if (secs == MAX_S6) begin
        mins_next = step_wrap(mins, MAX_M6, 1'b1);
        if (mins == MAX_M6)
          hours_next = HOUR_W'(step_wrap(MIN_W'(hours), MAX_H6, 1'b1));
      end
    end

    if (step) begin
      case (sel)
        SEL_TH: begin
          hours_next = HOUR_W'(step_wrap(MIN_W'(hours), MAX_H6, inc));
          secs_next  = '0;
        end
        SEL_TM: begin
          mins_next = step_wrap(mins, MAX_M6, inc);
          secs_next = '0;
        end
        SEL_AH:  alarm_hours_next = HOUR_W'(step_wrap(MIN_W'(alarm_hours), MAX_H6, inc));
        SEL_AM:  alarm_mins_next  = step_wrap(alarm_mins, MAX_M6, inc);
        default: ;
      endcase
    end
  end

  // Field registers; reset overrides tick and adjust.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hours       <= '0;
      mins        <= '0;
      secs        <= '0;
      alarm_hours <= '0;
      alarm_mins  <= '0;
    end else begin
      hours       <= hours_next;
      mins        <= mins_next;
      secs        <= secs_next;
      alarm_hours <= alarm_hours_next;
      alarm_mins  <= alarm_mins_next;
    end
  end

  assign Z = (hours == alarm_hours) && (mins == alarm_mins);

endmodule
